// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// start/done handshake; sum/cout/ovf change only when an addition completes.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] sa, sb, acc, acc_nx;
  logic [CW-1:0]    cnt;
  logic             cy, fs, fc;
  logic             load, step, last;

  full_adder u_fa (.a(sa[0]), .b(sb[0]), .c(cy), .s(fs), .co(fc));

  // Whole-word shift keeps WIDTH=1 legal: the new bit lands in the MSB.
  assign acc_nx = (acc >> 1) | (WIDTH'(fs) << (WIDTH - 1));
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    busy     = (state == SHIFT);
    case (state)
      IDLE: if (start) begin
        load     = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        step = 1'b1;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        sa  <= a;
        sb  <= b;
        cy  <= cin;
        cnt <= '0;
        acc <= '0;
      end else if (step) begin
        acc <= acc_nx;
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        cy  <= fc;
        cnt <= cnt + CW'(1);
        if (last) begin
          // cy here is the carry into the MSB, fc the carry out of it.
          sum  <= acc_nx;
          cout <= fc;
          ovf  <= fc ^ cy;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around one full-adder cell and a carry flip-flop; adds two WIDTH-bit operands LSB-first, one bit per clock.
- Directly upstream consumer of the full_adder cell: it feeds the cell's a/b/c inputs from shift registers and registers its sum/carry outputs back.
- Start/done handshake; the result is held stable until the next start.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition. Sampled only while idle.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum/cout/ovf are valid from this cycle onward.
- sum  output  WIDTH  result of the last completed addition.
- cout  output  1  carry-out of the MSB for the last completed addition.
- ovf  output  1  signed (two's-complement) overflow of the last completed addition.

Behaviour:
- Reset (async assert, any time):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry flop and bit counter are cleared to 0.
  - An in-flight addition is abandoned; no done pulse follows.
- FSM states: IDLE, SHIFT.
- IDLE:
  - start=1 at edge k → load sa=a, sb=b, cy=cin, cnt=0, acc=0; go to SHIFT.
  - busy goes high after edge k.
  - Operands are sampled only at edge k; later changes to a/b/cin are ignored.
- SHIFT: at each edge, run the full adder on fs=sa[0]^sb[0]^cy and fc=maj(sa[0],sb[0],cy), then:
  - acc <= {fs, acc[WIDTH-1:1]} (fill from MSB, shift right).
  - sa, sb shift right by 1.
  - cy <= fc.
  - cnt <= cnt+1.
- SHIFT completion, on the edge where cnt==WIDTH-1 (edge k+WIDTH):
  - sum <= {fs, acc[WIDTH-1:1]} (the final accumulated word).
  - cout <= fc.
  - ovf <= fc ^ cy (carry-out of MSB xor carry-into MSB).
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start accepted at edge k → done high from edge k+WIDTH to edge k+WIDTH+1. Exactly WIDTH busy cycles.
- done is high for exactly one cycle. sum/cout/ovf hold until the next completion or reset.
- sum/cout/ovf never show partial results. acc is internal only.
- start while busy is ignored: no restart, and the operand registers are unaffected.
- start high in the same cycle done is high is accepted, because state is already IDLE. This allows back-to-back operations with a period of WIDTH+1 cycles.
- start held high continuously: a new addition begins on every IDLE cycle.
- WIDTH=1: a single SHIFT cycle; the block behaves as a registered full adder, and ovf = cout ^ cin.
- cnt width is $clog2(WIDTH)+1 bits, so it cannot wrap before completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).

Test Plan:
- WIDTH=8, a=0xFF, b=0x01, cin=0, start pulse → done exactly 8 cycles after the accept edge; sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, ovf=1. Then a=0x0F, b=0xF0, cin=1 → sum=0x00, cout=1, ovf=0.
- Start a=0x12, b=0x34; 3 cycles later pulse start with a=0xAA, b=0x55 → single done; sum=0x46, cout=0. busy stays high for 8 cycles total.
- Start a=0x0A, b=0x05; assert rst 4 cycles in → busy=0, done=0, sum=0 immediately, with no later done. After release, start a=0x03, b=0x04 → sum=0x07.
- Hold start=1 with new operands applied on each done cycle → successive done pulses 9 cycles apart. Each sum matches a+b+cin, and sum is stable between pulses.
- WIDTH=1, all 8 (a,b,cin) combinations → {cout,sum} matches the full-adder truth table (sum=a^b^c, carry=maj), with done 1 cycle after each accept.
